seg7_scan_driver: RTL and testbench
===================================

// Module: seg7_scan_driver
// PURPOSE
//   Time-multiplexed driver for the 8-digit common-anode 7-segment display.
//   Shows a 32-bit value as 8 hex digits. Produces the active-low segment bus
//   inv_leds and the active-low digit enables enb_leds, the same pair the
//   bench 8x7seg decoder model consumes. Double-buffered: a new value never
//   tears mid-frame. Blank gap between digits suppresses ghosting.
// PARAMETERS
//   REFRESH_DIV   100000  clk cycles each digit is lit (>=2)
//   BLANK_CYCLES  1000    clk cycles all digits are off between digits (>=1)
// PORTS
//   clk          in   1   system clock
//   rst          in   1   synchronous, active-high reset
//   i_value      in   32  display value; digit n = i_value[4n+3:4n], digit 0 = rightmost
//   i_load       in   1   1-cycle strobe: capture i_value into shadow register
//   inv_leds     out  7   segments {g,f,e,d,c,b,a}, active-low
//   enb_leds     out  8   digit enables, active-low, enb_leds[n] = digit n
//   o_digit_idx  out  3   digit currently scanned
//   o_frame_done out  1   1-cycle pulse at the end of digit 7's lit period
// BEHAVIOUR
//   - Reset: state BLANK, idx=0, counter=0, shadow=active=0, pending=0;
//     inv_leds=7'h7F, enb_leds=8'hFF, o_digit_idx=0, o_frame_done=0.
//   - FSM BLANK -> ON -> BLANK. BLANK lasts exactly BLANK_CYCLES cycles:
//     enb_leds=8'hFF, inv_leds=7'h7F. ON lasts exactly REFRESH_DIV cycles:
//     enb_leds = ~(8'b1<<idx), inv_leds = decode(active nibble idx).
//   - All outputs are registered and change only on state/idx transitions.
//     No glitches within a phase.
//   - Leaving ON increments idx. Wrap 7->0. A frame is
//     8*(REFRESH_DIV+BLANK_CYCLES) cycles.
//   - Decode 0-F (active-low hex):
//     40 79 24 30 19 12 02 78 00 10 08 03 46 21 06 0E.
//   - i_load: shadow <= i_value, pending <= 1, on the next edge.
//     Repeated loads keep only the last value.
//   - Frame boundary (last ON cycle of idx 7): o_frame_done=1 for that one
//     cycle. If pending, then active <= shadow and pending <= 0.
//   - i_load in the same cycle as a frame boundary: the boundary copies the
//     pre-load shadow. The new value sets pending and is applied at the next
//     boundary.
//   - rst mid-phase: next cycle all outputs at reset values. Scan restarts at
//     BLANK, idx 0. Shadow and active are cleared.
//   - First frame after reset displays 0 on all digits (active=0). A load
//     becomes visible at most one frame + one digit period later.
// CONFIGURATION
//   SEG7_LZ_BLANK_EN defined: leading-zero blanking.
//     - Digit n (n>=1) is suppressed (enb_leds[n] stays 1, inv_leds=7'h7F)
//       when active[31:4n]==0.
//     - Digit 0 is always shown. Slot timing is unchanged.
//   Not defined: all 8 digits are lit every frame regardless of value.
// TESTING (REFRESH_DIV=16, BLANK_CYCLES=2: digit slot=18, frame=144 cycles)
//   1. Reset held 5 cycles -> inv_leds=7F, enb_leds=FF, o_digit_idx=0,
//      frame_done=0. Cycles 0-1 blank, cycles 2-17: enb=FE, inv=40.
//   2. Load 0x01234567, run 2 frames. Second frame: digit0 enb=FE inv=78,
//      digit3 enb=F7 inv=19, digit7 enb=7F inv=40. Each lit exactly 16
//      cycles.
//   3. Load 0x89ABCDEF -> per digit 0..7: 0E 06 21 46 03 08 10 00.
//      Also 0xFFFFFFFF -> all 0E.
//   4. Load 0x11111111, then load 0x22222222 while digit 3 is lit -> that
//      frame stays all 79. Next frame all 24. No mixed frame.
//   5. Assert i_load in the frame_done cycle -> following frame shows the
//      old shadow. Frame after that shows the new value. Also rst during ON
//      of digit 5 -> next cycle enb=FF, inv=7F, o_digit_idx=0.
//   6. SEG7_LZ_BLANK_EN, load 0x000000A5 -> only enb bits 0,1 ever go low
//      (inv 12, 08). Load 0 -> only digit 0 lit, inv=40. Without the macro:
//      all 8 digits lit.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed, double-buffered 8-digit hex driver for a common-anode 7-segment display.
// Define SEG7_LZ_BLANK_EN to enable leading-zero blanking of digits 7..1.
module seg7_scan_driver #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] i_value,
    input  logic        i_load,
    output logic [6:0]  inv_leds,
    output logic [7:0]  enb_leds,
    output logic [2:0]  o_digit_idx,
    output logic        o_frame_done
);

    localparam int MAX_CNT = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int CW      = $clog2(MAX_CNT);
    localparam logic [CW-1:0] ON_LAST    = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

    typedef enum logic [0:0] {
        ST_BLANK = 1'b0,
        ST_ON    = 1'b1
    } state_t;

    state_t        state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic [2:0]    idx, idx_next;
    logic [31:0]   shadow, active, active_next;
    logic          pending;
    logic          boundary;
    logic [3:0]    nibble;
    logic          digit_shown;
    logic          lit;
    logic [6:0]    seg_next;
    logic [7:0]    enb_next;
    logic          frame_done_next;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
        case (n)
            4'h0: hex_to_seg = 7'h40;
            4'h1: hex_to_seg = 7'h79;
            4'h2: hex_to_seg = 7'h24;
            4'h3: hex_to_seg = 7'h30;
            4'h4: hex_to_seg = 7'h19;
            4'h5: hex_to_seg = 7'h12;
            4'h6: hex_to_seg = 7'h02;
            4'h7: hex_to_seg = 7'h78;
            4'h8: hex_to_seg = 7'h00;
            4'h9: hex_to_seg = 7'h10;
            4'hA: hex_to_seg = 7'h08;
            4'hB: hex_to_seg = 7'h03;
            4'hC: hex_to_seg = 7'h46;
            4'hD: hex_to_seg = 7'h21;
            4'hE: hex_to_seg = 7'h06;
            default: hex_to_seg = 7'h0E;
        endcase
    endfunction

    // Outputs are computed from the next state so they register in step with it.
    always_comb begin
        state_next = state;
        idx_next   = idx;
        cnt_next   = cnt + 1'b1;
        boundary   = 1'b0;
        case (state)
            ST_BLANK: begin
                if (cnt == BLANK_LAST) begin
                    state_next = ST_ON;
                    cnt_next   = '0;
                end
            end
            ST_ON: begin
                if (cnt == ON_LAST) begin
                    state_next = ST_BLANK;
                    cnt_next   = '0;
                    idx_next   = idx + 3'd1;
                    boundary   = (idx == 3'd7);
                end
            end
            default: begin
                state_next = ST_BLANK;
                cnt_next   = '0;
            end
        endcase

        active_next = (boundary && pending) ? shadow : active;
        nibble      = 4'(active_next >> {idx_next, 2'b00});
`ifdef SEG7_LZ_BLANK_EN
        digit_shown = (idx_next == 3'd0) || ((active_next >> {idx_next, 2'b00}) != 32'd0);
`else
        digit_shown = 1'b1;
`endif
        lit             = (state_next == ST_ON) && digit_shown;
        seg_next        = lit ? hex_to_seg(nibble) : 7'h7F;
        enb_next        = lit ? ~(8'b1 << idx_next) : 8'hFF;
        frame_done_next = (state_next == ST_ON) && (idx_next == 3'd7) && (cnt_next == ON_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_BLANK;
            cnt          <= '0;
            idx          <= 3'd0;
            shadow       <= 32'd0;
            active       <= 32'd0;
            pending      <= 1'b0;
            inv_leds     <= 7'h7F;
            enb_leds     <= 8'hFF;
            o_frame_done <= 1'b0;
        end else begin
            state        <= state_next;
            cnt          <= cnt_next;
            idx          <= idx_next;
            active       <= active_next;
            inv_leds     <= seg_next;
            enb_leds     <= enb_next;
            o_frame_done <= frame_done_next;
            // A load coinciding with a boundary wins: the boundary took the old shadow.
            if (i_load) begin
                shadow  <= i_value;
                pending <= 1'b1;
            end else if (boundary) begin
                pending <= 1'b0;
            end
        end
    end

    assign o_digit_idx = idx;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: whole frames are checked cycle by cycle against
// per-digit expectations queued before each frame.
module tb_seg7_scan_driver;

    localparam int RD    = 16;
    localparam int BC    = 2;
    localparam int SLOT  = RD + BC;
    localparam int FRAME = 8 * SLOT;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] i_value = 32'd0;
    logic        i_load = 1'b0;
    logic [6:0]  inv_leds;
    logic [7:0]  enb_leds;
    logic [2:0]  o_digit_idx;
    logic        o_frame_done;

    always #5 clk = ~clk;

    seg7_scan_driver #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
        .clk(clk),
        .rst(rst),
        .i_value(i_value),
        .i_load(i_load),
        .inv_leds(inv_leds),
        .enb_leds(enb_leds),
        .o_digit_idx(o_digit_idx),
        .o_frame_done(o_frame_done)
    );

    typedef struct packed {
        logic [31:0]     value;
        logic [7:0][6:0] segs;
        logic [7:0]      lz_mask;
    } vec_t;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [14:0] exp_q[$];
    vec_t        vecs[7];
    logic [6:0]  lut[16];
    logic [31:0]     rv;
    logic [7:0][6:0] rsegs;
    logic [7:0]      rmask;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] shown_mask(input logic [7:0] lz);
`ifdef SEG7_LZ_BLANK_EN
        return lz;
`else
        return 8'hFF;
`endif
    endfunction

    function automatic logic [7:0][6:0] all_seg(input logic [6:0] s);
        return {8{s}};
    endfunction

    // Entered and left at the sample point of cycle 0 of a frame.
    task automatic check_frame(input logic [7:0][6:0] segs, input logic [7:0] lz,
                               input int la, input logic [31:0] va,
                               input int lb, input logic [31:0] vb);
        logic [7:0]  shown;
        logic [14:0] e;
        logic [18:0] want;
        shown = shown_mask(lz);
        e = 15'd0;
        for (int d = 0; d < 8; d++) begin
            if (shown[d]) exp_q.push_back({~(8'b1 << d), segs[d]});
            else          exp_q.push_back({8'hFF, 7'h7F});
        end
        for (int c = 0; c < FRAME; c++) begin
            int d;
            int k;
            d = c / SLOT;
            k = c % SLOT;
            if (k == 0) e = exp_q.pop_front();
            if (k < BC) want = {8'hFF, 7'h7F, 3'(d), 1'b0};
            else        want = {e, 3'(d), (d == 7 && k == SLOT - 1)};
            chk($sformatf("frame_cyc%0d", c),
                {13'd0, enb_leds, inv_leds, o_digit_idx, o_frame_done}, {13'd0, want});
            i_load = 1'b0;
            if (c == la) begin i_value = va; i_load = 1'b1; end
            if (c == lb) begin i_value = vb; i_load = 1'b1; end
            @(negedge clk);
        end
        i_load = 1'b0;
    endtask

    task automatic load(input logic [31:0] v);
        i_value = v;
        i_load  = 1'b1;
        @(negedge clk);
        i_load  = 1'b0;
    endtask

    // Leaves the bench at the sample point of cycle 0 of the following frame.
    task automatic wait_frame_done();
        int n;
        n = 0;
        while (o_frame_done !== 1'b1 && n < 2 * FRAME) begin
            @(negedge clk);
            n++;
        end
        chk("frame_done_seen", {31'd0, o_frame_done}, 32'd1);
        @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        lut = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        vecs[0] = '{32'h01234567, {7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78}, 8'h7F};
        vecs[1] = '{32'h89ABCDEF, {7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E}, 8'hFF};
        vecs[2] = '{32'hFFFFFFFF, {8{7'h0E}}, 8'hFF};
        vecs[3] = '{32'h000000A5, {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h08, 7'h12}, 8'h03};
        vecs[4] = '{32'h00000000, {8{7'h40}}, 8'h01};
        vecs[5] = '{32'h76543210, {7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40}, 8'hFF};
        rv = $urandom;
        rv[31:28] = 4'(1 + $urandom_range(0, 14));
        for (int d = 0; d < 8; d++) begin
            rsegs[d] = lut[4'(rv >> (4 * d))];
            rmask[d] = 1'b1;
        end
        vecs[6] = '{rv, rsegs, rmask};

        // Reset held, then release into the first frame (all zeros).
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("reset_out", {13'd0, enb_leds, inv_leds, o_digit_idx, o_frame_done},
            {13'd0, 8'hFF, 7'h7F, 3'd0, 1'b0});
        rst = 1'b0;
        check_frame(all_seg(7'h40), 8'h01, -1, 32'd0, -1, 32'd0);

        // Table vectors: load, let the boundary apply it, check the next frame.
        for (int i = 0; i < 7; i++) begin
            load(vecs[i].value);
            wait_frame_done();
            check_frame(vecs[i].segs, vecs[i].lz_mask, -1, 32'd0, -1, 32'd0);
        end

        // Mid-frame load must not tear the frame in progress.
        load(32'h11111111);
        wait_frame_done();
        check_frame(all_seg(7'h79), 8'hFF, 3 * SLOT + BC + 4, 32'h22222222, -1, 32'd0);
        check_frame(all_seg(7'h24), 8'hFF, -1, 32'd0, -1, 32'd0);

        // Load in the frame_done cycle: boundary takes the earlier shadow value.
        check_frame(all_seg(7'h24), 8'hFF, 10, 32'h33333333, FRAME - 1, 32'h44444444);
        check_frame(all_seg(7'h30), 8'hFF, -1, 32'd0, -1, 32'd0);
        check_frame(all_seg(7'h19), 8'hFF, -1, 32'd0, -1, 32'd0);

        // Reset while digit 5 is lit.
        repeat (5 * SLOT + BC + 5) @(negedge clk);
        chk("digit5_lit", {24'd0, enb_leds}, 32'hDF);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_reset_out", {13'd0, enb_leds, inv_leds, o_digit_idx, o_frame_done},
            {13'd0, 8'hFF, 7'h7F, 3'd0, 1'b0});
        rst = 1'b0;
        check_frame(all_seg(7'h40), 8'h01, -1, 32'd0, -1, 32'd0);

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
